// File: rtl/lc_noc_pkg.sv
// Shared constants and types for the local-controller NoC endpoints.
package lc_noc_pkg;

    localparam int DATAWIDTH      = 16;
    localparam int ADDR_VEC_WIDTH = 8;
    localparam int PACKET_WIDTH   = 2*DATAWIDTH + ADDR_VEC_WIDTH;

    localparam int DEST_LSB    = 0;
    localparam int PAYLOAD_LSB = ADDR_VEC_WIDTH;

    typedef enum logic {IDLE, HOLD} arb_state_t;

endpackage

// File: rtl/lc_rx_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two >= 2.
module lc_rx_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr, rd_ptr;
    logic                        do_push, do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/lc_packet_receiver.sv
// NoC destination endpoint: filters on the one-hot dest bit, buffers payloads.
// Optional prefetch channel built when LC_RX_PREFETCH_EN is defined.
module lc_packet_receiver
    import lc_noc_pkg::*;
#(
    parameter int datawidth            = DATAWIDTH,
    parameter int address_vector_width = ADDR_VEC_WIDTH,
    parameter int packet_width         = 2*datawidth + address_vector_width,
    parameter int MY_INDEX             = 0,
    parameter int DEPTH                = 4
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic [packet_width-1:0]   packet_in,
    input  logic                      packet_valid,
    output logic                      packet_ready,
    input  logic [packet_width-1:0]   prefetch_packet_in,
    input  logic                      prefetch_packet_valid,
    output logic                      prefetch_packet_ready,
    output logic [2*datawidth-1:0]    out_data,
    output logic                      out_is_prefetch,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [7:0]                drop_count,
    output logic [$clog2(DEPTH):0]    fifo_level
);

    localparam int PW = 2*datawidth;
`ifdef LC_RX_PREFETCH_EN
    localparam int FW = PW + 1;
`else
    localparam int FW = PW;
`endif

    logic          full, empty, push, pop;
    logic [FW-1:0] push_data, head;
    logic          s_hs, s_match;
    logic [PW-1:0] s_payload;
    logic [1:0]    drop_inc;
    logic [8:0]    drop_sum;

    assign s_hs      = packet_valid && packet_ready;
    assign s_match   = packet_in[MY_INDEX];
    assign s_payload = packet_in[packet_width-1:address_vector_width];

`ifdef LC_RX_PREFETCH_EN
    arb_state_t    state;
    logic          stream_pending;
    logic [PW-1:0] pf_hold;
    logic          pf_hs, pf_match;
    logic [PW-1:0] pf_payload;
    logic          unused_dest;

    assign unused_dest = ^{packet_in[address_vector_width-1:0],
                           prefetch_packet_in[address_vector_width-1:0]};

    assign packet_ready          = !reset && !full && (state == IDLE);
    assign prefetch_packet_ready = !reset && !full && !stream_pending && (state == IDLE);
    assign pf_hs      = prefetch_packet_valid && prefetch_packet_ready;
    assign pf_match   = prefetch_packet_in[MY_INDEX];
    assign pf_payload = prefetch_packet_in[packet_width-1:address_vector_width];

    // The held prefetch packet always goes first; stream beats a fresh prefetch.
    always_comb begin
        push      = 1'b0;
        push_data = '0;
        if (state == HOLD) begin
            push      = !full;
            push_data = {1'b1, pf_hold};
        end else if (s_hs && s_match) begin
            push      = 1'b1;
            push_data = {1'b0, s_payload};
        end else if (pf_hs && !s_hs && pf_match) begin
            push      = 1'b1;
            push_data = {1'b1, pf_payload};
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state          <= IDLE;
            stream_pending <= 1'b0;
            pf_hold        <= '0;
        end else begin
            stream_pending <= s_hs;
            case (state)
                IDLE: if (s_hs && pf_hs && pf_match) begin
                    pf_hold <= pf_payload;
                    state   <= HOLD;
                end
                HOLD: if (!full) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign drop_inc        = {1'b0, s_hs && !s_match} + {1'b0, pf_hs && !pf_match};
    assign out_is_prefetch = head[PW];
`else
    logic unused_prefetch;

    assign unused_prefetch = ^{prefetch_packet_in, prefetch_packet_valid,
                               packet_in[address_vector_width-1:0]};

    assign packet_ready          = !reset && !full;
    assign prefetch_packet_ready = 1'b0;
    assign push                  = s_hs && s_match;
    assign push_data             = s_payload;
    assign drop_inc              = {1'b0, s_hs && !s_match};
    assign out_is_prefetch       = 1'b0;
`endif

    assign pop       = !empty && out_ready;
    assign out_valid = !empty;
    assign out_data  = head[PW-1:0];

    lc_rx_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
        .clk       (CLK),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    assign drop_sum = {1'b0, drop_count} + {7'b0, drop_inc};

    always_ff @(posedge CLK) begin
        if (reset)
            drop_count <= '0;
        else
            drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

endmodule
